// File: rtl/fetch_ram_fifo_ctrl_if.sv
// rtl/fetch_ram_fifo_ctrl_if.sv - producer/consumer handshake bundle for the fetch RAM FIFO
//
// Purpose: groups the push (producer) and pop (consumer) handshakes of the
// fetch RAM FIFO controller.
// Signals:
//   wr_req  producer requests a push
//   wr_dat  push data, held stable by the producer until wr_ack
//   wr_ack  push accepted this cycle
//   rd_req  consumer requests a pop
//   rd_ack  pop accepted this cycle
//   rd_val  rd_dat valid, one cycle after rd_ack
//   rd_dat  pop data
// Modports: master = requester side, slave = FIFO controller side.

interface fetch_ram_fifo_ctrl_if #(
    parameter int Word_Width = 128
);
    logic                  wr_req;
    logic [Word_Width-1:0] wr_dat;
    logic                  wr_ack;
    logic                  rd_req;
    logic                  rd_ack;
    logic                  rd_val;
    logic [Word_Width-1:0] rd_dat;

    modport master (
        output wr_req,
        output wr_dat,
        input  wr_ack,
        output rd_req,
        input  rd_ack,
        input  rd_val,
        input  rd_dat
    );

    modport slave (
        input  wr_req,
        input  wr_dat,
        output wr_ack,
        input  rd_req,
        output rd_ack,
        output rd_val,
        output rd_dat
    );
endinterface

// File: rtl/fetch_ram_fifo_ctrl.sv
// rtl/fetch_ram_fifo_ctrl.sv - single-port fetch SRAM run as a circular FIFO
//
// Purpose: shares one single-port SRAM (active-low cen/wen/oen, 1-cycle read
// latency) between a DDR-fetch producer and an encoder-engine consumer.
// One access per cycle, round-robin on contention, occupancy tracking.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush_i           synchronous clear of FIFO state, highest priority
//   bus (slave)       push/pop handshakes, see fetch_ram_fifo_ctrl_if
//   full_o, empty_o   occupancy flags
//   count_o           occupancy 0..2^Addr_Width
//   sram_cen_o        SRAM chip enable (active low)
//   sram_wen_o        SRAM write enable (active low)
//   sram_oen_o        SRAM output enable (active low)
//   sram_addr_o       SRAM address
//   sram_dat_o        SRAM write data
//   sram_dat_i        SRAM read data

module fetch_ram_fifo_ctrl #(
    parameter int Word_Width = 128,
    parameter int Addr_Width = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    fetch_ram_fifo_ctrl_if.slave  bus,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [Addr_Width:0]   count_o,
    output logic                  sram_cen_o,
    output logic                  sram_wen_o,
    output logic                  sram_oen_o,
    output logic [Addr_Width-1:0] sram_addr_o,
    output logic [Word_Width-1:0] sram_dat_o,
    input  logic [Word_Width-1:0] sram_dat_i
);

    localparam logic [Addr_Width:0]   Depth    = {1'b1, {Addr_Width{1'b0}}};
    localparam logic [Addr_Width:0]   CountOne = {{Addr_Width{1'b0}}, 1'b1};
    localparam logic [Addr_Width-1:0] PtrOne   = {{(Addr_Width-1){1'b0}}, 1'b1};

    logic [Addr_Width-1:0] wr_ptr;
    logic [Addr_Width-1:0] rd_ptr;
    logic [Addr_Width:0]   count;
    logic                  pri;      // 0: write wins a tie, 1: read wins
    logic                  rd_val;
    logic                  oen_n;

    logic push_ok;
    logic pop_ok;
    logic wr_gnt;
    logic rd_gnt;
    logic contended;

    assign full_o  = (count == Depth);
    assign empty_o = (count == '0);
    assign count_o = count;

    // Eligibility uses the registered count only, so a word pushed this
    // cycle cannot be popped until the next one (no write-to-read bypass).
    assign push_ok   = bus.wr_req & ~full_o  & ~flush_i;
    assign pop_ok    = bus.rd_req & ~empty_o & ~flush_i;
    assign contended = push_ok & pop_ok;

    assign wr_gnt = push_ok & (~pop_ok | ~pri);
    assign rd_gnt = pop_ok  & (~push_ok | pri);

    assign bus.wr_ack = wr_gnt;
    assign bus.rd_ack = rd_gnt;
    assign bus.rd_val = rd_val;
    assign bus.rd_dat = sram_dat_i;

    always_comb begin
        sram_cen_o  = 1'b1;
        sram_wen_o  = 1'b1;
        sram_addr_o = rd_ptr;
        if (wr_gnt) begin
            sram_cen_o  = 1'b0;
            sram_wen_o  = 1'b0;
            sram_addr_o = wr_ptr;
        end else if (rd_gnt) begin
            sram_cen_o  = 1'b0;
        end
    end

    assign sram_dat_o = bus.wr_dat;
    assign sram_oen_o = oen_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pri    <= 1'b0;
            rd_val <= 1'b0;
            oen_n  <= 1'b1;
        end else begin
            // Read return tracks the previous cycle's grant; a grant made just
            // before a flush still completes during the flush cycle.
            rd_val <= rd_gnt;
            oen_n  <= ~rd_gnt;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                pri    <= 1'b0;
            end else begin
                if (wr_gnt) begin
                    wr_ptr <= wr_ptr + PtrOne;
                    count  <= count + CountOne;
                end else if (rd_gnt) begin
                    rd_ptr <= rd_ptr + PtrOne;
                    count  <= count - CountOne;
                end
                // Only a real tie moves the priority, so a lone requester
                // never steals the other side's next turn.
                if (contended) begin
                    pri <= ~pri;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_ram_fifo_ctrl.sv
// tb/tb_fetch_ram_fifo_ctrl.sv - scoreboard bench for fetch_ram_fifo_ctrl

module tb_fetch_ram_fifo_ctrl;

    localparam int Ww = 128;
    localparam int Aw = 5;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            full;
    logic            empty;
    logic [Aw:0]     count;
    logic            sram_cen;
    logic            sram_wen;
    logic            sram_oen;
    logic [Aw-1:0]   sram_addr;
    logic [Ww-1:0]   sram_wdat;
    logic [Ww-1:0]   sram_rdat;

    fetch_ram_fifo_ctrl_if #(.Word_Width(Ww)) bus ();

    fetch_ram_fifo_ctrl #(.Word_Width(Ww), .Addr_Width(Aw)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .bus         (bus.slave),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count),
        .sram_cen_o  (sram_cen),
        .sram_wen_o  (sram_wen),
        .sram_oen_o  (sram_oen),
        .sram_addr_o (sram_addr),
        .sram_dat_o  (sram_wdat),
        .sram_dat_i  (sram_rdat)
    );

    // Behavioural ram_1p beside the controller
    logic [Ww-1:0] mem [32];
    logic [Ww-1:0] ram_q;
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_addr] <= sram_wdat;
            else           ram_q <= mem[sram_addr];
        end
    end
    assign sram_rdat = sram_oen ? '0 : ram_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [Ww-1:0] data_q [$];   // words held in the model FIFO
    logic [Ww-1:0] exp_q  [$];   // words expected on rd_val, in order
    logic [Aw-1:0] m_wptr;
    logic [Aw-1:0] m_rptr;
    int            m_count;
    logic          last_er;

    task automatic chk(input string name, input logic [Ww-1:0] act, input logic [Ww-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [Ww-1:0] word(input int tag, input int i);
        return {32'(tag), 32'(i), 32'hC0DE_0000 | 32'(i), ~32'(i)};
    endfunction

    task automatic model_reset();
        data_q.delete();
        exp_q.delete();
        m_wptr  = '0;
        m_rptr  = '0;
        m_count = 0;
        last_er = 1'b0;
    endtask

    // One clock cycle of stimulus with hand-derived expected acks
    task automatic step(input logic w, input logic [Ww-1:0] d, input logic r,
                        input logic f, input logic ew, input logic er);
        logic [Aw+1:0] exp_pins;
        @(posedge clk);
        #1;
        bus.wr_req = w;
        bus.wr_dat = d;
        bus.rd_req = r;
        flush      = f;
        #2;
        chk("wr_ack", Ww'(bus.wr_ack), Ww'(ew));
        chk("rd_ack", Ww'(bus.rd_ack), Ww'(er));
        if (ew)      exp_pins = {1'b0, 1'b0, m_wptr};
        else if (er) exp_pins = {1'b0, 1'b1, m_rptr};
        else         exp_pins = {1'b1, 1'b1, m_rptr};
        chk("sram_cen_wen_addr", Ww'({sram_cen, sram_wen, sram_addr}), Ww'(exp_pins));
        chk("sram_dat_o", sram_wdat, d);
        chk("count", Ww'(count), Ww'(m_count));
        chk("full_empty", Ww'({full, empty}), Ww'({m_count == 32, m_count == 0}));
        chk("rd_val_oen", Ww'({bus.rd_val, sram_oen}), Ww'({last_er, ~last_er}));
        last_er = er;
        if (ew) begin
            data_q.push_back(d);
            m_wptr++;
            m_count++;
        end
        if (er) begin
            exp_q.push_back(data_q.pop_front());
            m_rptr++;
            m_count--;
        end
        if (f) begin
            data_q.delete();
            m_wptr  = '0;
            m_rptr  = '0;
            m_count = 0;
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every valid strobe consumes the oldest expected word
    always @(negedge clk) begin
        if (rst_n && bus.rd_val) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_val_unexpected: got rd_dat %h expected no valid", bus.rd_dat);
            end else begin
                chk("rd_dat", bus.rd_dat, exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        bus.wr_req = 1'b0;
        bus.wr_dat = '0;
        bus.rd_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", Ww'({bus.rd_val, sram_oen, empty, full, count}),
            Ww'({1'b0, 1'b1, 1'b1, 1'b0, 6'd0}));
        @(negedge clk);
        rst_n = 1'b1;

        // Push three, then pop three
        for (int i = 0; i < 3; i++) step(1'b1, word(16'hA0, i), 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();

        // Flush to zero pointers, fill to 32, stall, pop, wrap-around push
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b1, word(16'hB0, i), 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, word(16'hB0, 32), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, word(16'hB0, 32), 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 22; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Contention at count 10: W,R,W,R,W,R
        for (int c = 0; c < 6; c++)
            step(1'b1, word(16'hC0, (c + 1) / 2), 1'b1, 1'b0, (c % 2) == 0, (c % 2) == 1);
        idle();

        // Drain, then simultaneous requests on an empty FIFO
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, word(16'hD0, 0), 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();

        // 70 push/pop pairs, pointers wrap twice
        for (int i = 0; i < 70; i++) begin
            step(1'b1, word(16'hE0, i), 1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        idle();

        // Flush in the cycle after a read ack, count 5 before the pop
        for (int i = 0; i < 5; i++) step(1'b1, word(16'hF0, i), 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, word(16'hF0, 9), 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, word(16'hF1, 0), 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();

        // Reset while a read is in flight
        step(1'b1, word(16'hF2, 0), 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, word(16'hF2, 1), 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        bus.rd_req = 1'b0;
        #1;
        chk("reset_inflight", Ww'({bus.rd_val, sram_oen, count, empty}),
            Ww'({1'b0, 1'b1, 6'd0, 1'b1}));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, word(16'hF3, 0), 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        idle();

        chk("scoreboard_drained", Ww'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
